// File: rtl/verlet_frame_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// verlet_pkg
//   Shared definitions for the rope-simulation frame scheduler and the node
//   array it drives: the scheduler state encoding, the shared-ALU opcodes and
//   the rest-position constants that the node array uses for the rope layout.
// ---------------------------------------------------------------------------
package verlet_pkg;

    // Frame scheduler states: a request/wait/latch triple per ALU operation
    // for each of the two phases, plus idle and a one-cycle completion state.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_V_REQ   = 3'd1,
        ST_V_WAIT  = 3'd2,
        ST_V_LATCH = 3'd3,
        ST_C_REQ   = 3'd4,
        ST_C_WAIT  = 3'd5,
        ST_C_LATCH = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    // Shared-ALU opcodes: Verlet integration uses the multiply path,
    // constraint relaxation uses the subtract path.
    localparam logic [4:0] OP_VERLET = 5'd2;
    localparam logic [4:0] OP_CONSTR = 5'd1;
    localparam logic [4:0] OP_NONE   = 5'd0;

    // Rope layout: x coordinate of the pinned node and rest spacing between
    // neighbouring nodes.
    localparam logic [15:0] BASE_X = 16'd200;
    localparam logic [15:0] DIST   = 16'd10;

endpackage

// File: rtl/verlet_frame_scheduler_alu_watchdog.sv
// ---------------------------------------------------------------------------
// alu_watchdog
//   Counts cycles spent waiting for the shared ALU result. The count is held
//   at zero while clear is high, advances while enable is high and saturates
//   at LIMIT-1; expired is high whenever the count sits at that terminal value.
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   clear    in   synchronous clear of the cycle count
//   enable   in   count this cycle
//   expired  out  count has reached LIMIT-1
// ---------------------------------------------------------------------------
module alu_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_r;

    // Saturating wait-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != TERMINAL)) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign expired = (count_r == TERMINAL);

endmodule

// File: rtl/verlet_frame_scheduler.sv
// ---------------------------------------------------------------------------
// verlet_frame_scheduler
//   Sequences one simulation frame for NUM_NODES rope nodes sharing a single
//   floating-point ALU. Phase 1 issues one Verlet-integration op per node
//   (nodes 0..NUM_NODES-1); phase 2 issues one constraint op per unpinned
//   node (1..NUM_NODES-1), repeated ITERS times. Each op is a request /
//   wait / latch sequence; the latch cycle pulses the node's one-hot strobe.
//   A watchdog aborts the frame if the ALU result does not return in time.
// Ports
//   clk                   in   clock, rising edge
//   reset                 in   asynchronous active-low reset
//   frame_start           in   one-cycle pulse: begin a frame (idle only)
//   alu_valid             out  ALU request, held until alu_ready
//   alu_ready             in   ALU accepts the request this cycle
//   alu_done              in   ALU result valid (one-cycle pulse)
//   alu_op                out  ALU opcode (0 when idle / done)
//   alu_sel               out  node whose operands are muxed into the ALU
//   verlet_state          out  one-hot one-cycle Verlet latch strobe
//   fix_constraint_state  out  one-hot one-cycle constraint latch strobe
//   busy                  out  frame in progress
//   frame_done            out  one-cycle pulse at frame completion
//   timeout_err           out  sticky ALU timeout flag, cleared by frame_start
// ---------------------------------------------------------------------------
module verlet_frame_scheduler
    import verlet_pkg::*;
#(
    parameter int NUM_NODES   = 8,
    parameter int ITERS       = 4,
    parameter int ALU_TIMEOUT = 64,
    parameter int NODE_W      = $clog2(NUM_NODES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    output logic                 alu_valid,
    input  logic                 alu_ready,
    input  logic                 alu_done,
    output logic [4:0]           alu_op,
    output logic [NODE_W-1:0]    alu_sel,
    output logic [NUM_NODES-1:0] verlet_state,
    output logic [NUM_NODES-1:0] fix_constraint_state,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 timeout_err
);

    localparam int ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [NODE_W-1:0] LAST_NODE  = NODE_W'(NUM_NODES - 1);
    localparam logic [NODE_W-1:0] FIRST_NODE = NODE_W'(0);
    // Node 0 is pinned, so constraint passes start at node 1.
    localparam logic [NODE_W-1:0] FIRST_FREE = NODE_W'(1);
    localparam logic [ITER_W-1:0] LAST_ITER  = ITER_W'(ITERS - 1);

    state_t            state_r;
    logic [NODE_W-1:0] node_r;
    logic [ITER_W-1:0] iter_r;
    logic              in_wait_s;
    logic              wd_expired_s;

    // One-hot strobe for a node index.
    function automatic logic [NUM_NODES-1:0] node_onehot(input logic [NODE_W-1:0] idx);
        logic [NUM_NODES-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    assign in_wait_s = (state_r == ST_V_WAIT) || (state_r == ST_C_WAIT);

    // The watchdog is held clear outside the wait states, so every wait
    // starts counting from zero at the cycle after acceptance.
    alu_watchdog #(
        .LIMIT (ALU_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (~in_wait_s),
        .enable  (in_wait_s),
        .expired (wd_expired_s)
    );

    // Frame FSM; every output is a register updated together with the state,
    // so each output value lines up with the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r              <= ST_IDLE;
            node_r               <= '0;
            iter_r               <= '0;
            alu_valid            <= 1'b0;
            alu_op               <= OP_NONE;
            alu_sel              <= '0;
            verlet_state         <= '0;
            fix_constraint_state <= '0;
            busy                 <= 1'b0;
            frame_done           <= 1'b0;
            timeout_err          <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            verlet_state         <= '0;
            fix_constraint_state <= '0;
            frame_done           <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_r     <= ST_V_REQ;
                        node_r      <= FIRST_NODE;
                        iter_r      <= '0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        alu_valid   <= 1'b1;
                        alu_op      <= OP_VERLET;
                        alu_sel     <= FIRST_NODE;
                    end
                end

                ST_V_REQ: begin
                    if (alu_ready) begin
                        state_r   <= ST_V_WAIT;
                        alu_valid <= 1'b0;
                    end
                end

                // Result wins over a same-cycle watchdog expiry.
                ST_V_WAIT: begin
                    if (alu_done) begin
                        state_r      <= ST_V_LATCH;
                        verlet_state <= node_onehot(node_r);
                    end else if (wd_expired_s) begin
                        state_r     <= ST_IDLE;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        alu_op      <= OP_NONE;
                        alu_sel     <= '0;
                    end
                end

                ST_V_LATCH: begin
                    alu_valid <= 1'b1;
                    if (node_r == LAST_NODE) begin
                        state_r <= ST_C_REQ;
                        node_r  <= FIRST_FREE;
                        alu_op  <= OP_CONSTR;
                        alu_sel <= FIRST_FREE;
                    end else begin
                        state_r <= ST_V_REQ;
                        node_r  <= node_r + NODE_W'(1);
                        alu_op  <= OP_VERLET;
                        alu_sel <= node_r + NODE_W'(1);
                    end
                end

                ST_C_REQ: begin
                    if (alu_ready) begin
                        state_r   <= ST_C_WAIT;
                        alu_valid <= 1'b0;
                    end
                end

                ST_C_WAIT: begin
                    if (alu_done) begin
                        state_r              <= ST_C_LATCH;
                        fix_constraint_state <= node_onehot(node_r);
                    end else if (wd_expired_s) begin
                        state_r     <= ST_IDLE;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        alu_op      <= OP_NONE;
                        alu_sel     <= '0;
                    end
                end

                // End of a constraint pass either starts the next pass at
                // node 1 or, after the final pass, completes the frame.
                ST_C_LATCH: begin
                    if (node_r != LAST_NODE) begin
                        state_r   <= ST_C_REQ;
                        node_r    <= node_r + NODE_W'(1);
                        alu_valid <= 1'b1;
                        alu_op    <= OP_CONSTR;
                        alu_sel   <= node_r + NODE_W'(1);
                    end else if (iter_r != LAST_ITER) begin
                        state_r   <= ST_C_REQ;
                        node_r    <= FIRST_FREE;
                        iter_r    <= iter_r + ITER_W'(1);
                        alu_valid <= 1'b1;
                        alu_op    <= OP_CONSTR;
                        alu_sel   <= FIRST_FREE;
                    end else begin
                        state_r    <= ST_DONE;
                        frame_done <= 1'b1;
                        alu_op     <= OP_NONE;
                        alu_sel    <= '0;
                    end
                end

                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    state_r   <= ST_IDLE;
                    node_r    <= '0;
                    iter_r    <= '0;
                    alu_valid <= 1'b0;
                    alu_op    <= OP_NONE;
                    alu_sel   <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_verlet_frame_scheduler.sv
// Directed bench for verlet_frame_scheduler with NUM_NODES=4, ITERS=2,
// ALU_TIMEOUT=64. Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, i.e. away from the active edge.
module tb_verlet_frame_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       alu_ready;
    logic       alu_done;
    logic       alu_valid;
    logic [4:0] alu_op;
    logic [1:0] alu_sel;
    logic [3:0] verlet_state;
    logic [3:0] fix_constraint_state;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;

    verlet_frame_scheduler #(
        .NUM_NODES   (4),
        .ITERS       (2),
        .ALU_TIMEOUT (64)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .frame_start          (frame_start),
        .alu_valid            (alu_valid),
        .alu_ready            (alu_ready),
        .alu_done             (alu_done),
        .alu_op               (alu_op),
        .alu_sel              (alu_sel),
        .verlet_state         (verlet_state),
        .fix_constraint_state (fix_constraint_state),
        .busy                 (busy),
        .frame_done           (frame_done),
        .timeout_err          (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        c0 = cyc;
        chk("start_busy", busy, 1);
        chk("start_terr", timeout_err, 0);
    endtask

    // Starts in the REQ state of node n and ends in the state after LATCH.
    task automatic do_op(input logic constr, input int n, input int rdy_wait, input logic noise);
        logic [4:0] op_exp;
        logic [3:0] oh;
        op_exp = constr ? 5'd1 : 5'd2;
        oh     = 4'b0001 << n;
        chk("req_valid", alu_valid, 1);
        chk("req_sel", alu_sel, n);
        chk("req_op", alu_op, op_exp);
        for (int k = 0; k < rdy_wait; k++) begin
            if (noise && (k == 0)) begin
                frame_start = 1'b1;
                alu_done    = 1'b1;
            end
            tick();
            frame_start = 1'b0;
            alu_done    = 1'b0;
            chk("stall_valid", alu_valid, 1);
            chk("stall_sel", alu_sel, n);
            chk("stall_op", alu_op, op_exp);
            chk("stall_pulses", {verlet_state, fix_constraint_state}, 0);
        end
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
        chk("wait_valid", alu_valid, 0);
        chk("wait_pulses", {verlet_state, fix_constraint_state}, 0);
        // Constraint ops also present alu_ready alongside alu_done.
        alu_ready = constr;
        alu_done  = 1'b1;
        tick();
        alu_ready = 1'b0;
        alu_done  = 1'b0;
        chk("latch_verlet", verlet_state, constr ? 4'b0000 : oh);
        chk("latch_constr", fix_constraint_state, constr ? oh : 4'b0000);
        tick();
        chk("post_pulses", {verlet_state, fix_constraint_state}, 0);
    endtask

    task automatic all_ops(input int rdy0, input logic noise);
        for (int n = 0; n < 4; n++)
            do_op(1'b0, n, (n == 0) ? rdy0 : 0, noise && (n == 0));
        for (int it = 0; it < 2; it++)
            for (int n = 1; n < 4; n++)
                do_op(1'b1, n, 0, 1'b0);
    endtask

    task automatic finish_frame(input int exp_len);
        chk("done_pulse", frame_done, 1);
        chk("done_busy", busy, 1);
        chk("done_sel", alu_sel, 0);
        chk("done_op", alu_op, 0);
        chk("frame_len", cyc - c0, exp_len);
        tick();
        chk("idle_done", frame_done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        reset       = 1'b0;
        frame_start = 1'b0;
        alu_ready   = 1'b0;
        alu_done    = 1'b0;
        #12;
        chk("rst_valid", alu_valid, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_sel", alu_sel, 0);
        chk("rst_pulses", {verlet_state, fix_constraint_state}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_terr", timeout_err, 0);
        #1 reset = 1'b1;
        tick();
        chk("idle_busy0", busy, 0);

        // Best case: 10 ops x 3 cycles; frame_done is in the 31st cycle
        // after the frame_start cycle (cycle 32 counting frame_start as 1).
        start_frame();
        all_ops(0, 1'b0);
        finish_frame(30);

        // alu_ready withheld for 5 cycles on node 0.
        start_frame();
        all_ops(5, 1'b0);
        finish_frame(35);

        // Stray frame_start and alu_done during V_REQ are ignored.
        start_frame();
        all_ops(2, 1'b1);
        finish_frame(32);

        // Timeout in C_WAIT of node 1: abort after 64 wait cycles.
        start_frame();
        for (int n = 0; n < 4; n++)
            do_op(1'b0, n, 0, 1'b0);
        chk("to_req_valid", alu_valid, 1);
        chk("to_req_op", alu_op, 5'd1);
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
        repeat (63) tick();
        chk("to_63_busy", busy, 1);
        chk("to_63_terr", timeout_err, 0);
        tick();
        chk("to_terr", timeout_err, 1);
        chk("to_busy", busy, 0);
        chk("to_valid", alu_valid, 0);
        chk("to_sel", alu_sel, 0);
        chk("to_op", alu_op, 0);
        chk("to_pulses", {verlet_state, fix_constraint_state}, 0);
        chk("to_done", frame_done, 0);
        repeat (3) tick();
        chk("to_sticky", timeout_err, 1);
        chk("to_done_late", frame_done, 0);
        start_frame();
        all_ops(0, 1'b0);
        finish_frame(30);

        // Asynchronous reset in V_WAIT of node 2.
        start_frame();
        do_op(1'b0, 0, 0, 1'b0);
        do_op(1'b0, 1, 0, 1'b0);
        chk("ar_req_sel", alu_sel, 2);
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
        chk("ar_wait_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", alu_valid, 0);
        chk("ar_sel", alu_sel, 0);
        chk("ar_op", alu_op, 0);
        chk("ar_busy", busy, 0);
        chk("ar_pulses", {verlet_state, fix_constraint_state}, 0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("ar_held_pulses", {verlet_state, fix_constraint_state}, 0);
        #2 reset = 1'b1;
        tick();
        chk("ar_rel_busy", busy, 0);
        chk("ar_rel_pulses", {verlet_state, fix_constraint_state}, 0);
        start_frame();
        all_ops(0, 1'b0);
        finish_frame(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
